// File: rtl/blit_pkg.sv
// Shared blitter data-adder definitions: phase codes, sequencer states, enable bundle.
package blit_pkg;

  localparam int unsigned CNT_W_DEF = 3;

  localparam logic [2:0] DADDB_SRCLO = 3'b000;
  localparam logic [2:0] DADDB_SRCHI = 3'b001;
  localparam logic [2:0] DADDB_IINC  = 3'b010;
  localparam logic [2:0] DADDB_ZINC  = 3'b011;
  localparam logic [2:0] DADDB_IDLE  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SRCLO = 3'd1,
    ST_SRCHI = 3'd2,
    ST_IINC  = 3'd3,
    ST_ZINC  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef struct packed {
    logic src;
    logic gourd;
    logic gourz;
  } phase_en_t;

  // First enabled phase of a repeat, or DONE when nothing is enabled.
  function automatic state_e first_phase(input phase_en_t en);
    if (en.src)        return ST_SRCLO;
    else if (en.gourd) return ST_IINC;
    else if (en.gourz) return ST_ZINC;
    else               return ST_DONE;
  endfunction

  // True for the states that drive the adder.
  function automatic logic is_phase(input state_e s);
    return (s == ST_SRCLO) || (s == ST_SRCHI) || (s == ST_IINC) || (s == ST_ZINC);
  endfunction

  // True when s is the final enabled phase of one repeat.
  function automatic logic is_last_phase(input state_e s, input phase_en_t en);
    case (s)
      ST_SRCHI: return !en.gourd && !en.gourz;
      ST_IINC:  return !en.gourz;
      ST_ZINC:  return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

  // B-mux select code for a state; non-phase states drive the idle code.
  function automatic logic [2:0] sel_code(input state_e s);
    case (s)
      ST_SRCLO: return DADDB_SRCLO;
      ST_SRCHI: return DADDB_SRCHI;
      ST_IINC:  return DADDB_IINC;
      ST_ZINC:  return DADDB_ZINC;
      default:  return DADDB_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/dadd_phase_next.sv
// Next-enabled-phase and end-of-repeat decode for the data-adder sequencer.
module dadd_phase_next
  import blit_pkg::*;
(
  input  state_e    cur,
  input  phase_en_t en,
  output state_e    nxt_phase_c,
  output logic      wrap_c
);

  // Walk SRCLO -> SRCHI -> IINC -> ZINC skipping disabled phases; wrap to the first one.
  always_comb begin
    wrap_c      = is_last_phase(cur, en);
    nxt_phase_c = first_phase(en);
    case (cur)
      ST_SRCLO: nxt_phase_c = ST_SRCHI;
      ST_SRCHI: begin
        if (en.gourd)      nxt_phase_c = ST_IINC;
        else if (en.gourz) nxt_phase_c = ST_ZINC;
      end
      ST_IINC: begin
        if (en.gourz) nxt_phase_c = ST_ZINC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dadd_step_sequencer.sv
// Sequences the data-adder B-mux select and result load across one blit step.
module dadd_step_sequencer
  import blit_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             sys_clk,
  input  logic             resetl,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_src,
  input  logic             cmd_gourd,
  input  logic             cmd_gourz,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic             abort,
  input  logic             dadd_stall,
  output logic             daddbsel_0,
  output logic             daddbsel_1,
  output logic             daddbsel_2,
  output logic             dadd_ld,
  output logic             dadd_last,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = CNT_W + 1;

  state_e      state_q, state_d;
  phase_en_t   en_q, en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  sel_q, sel_d;
  logic        ld_q, ld_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

  state_e      nxt_phase_c;
  logic        wrap_c;

  dadd_phase_next u_phase_next (
    .cur         (state_q),
    .en          (en_q),
    .nxt_phase_c (nxt_phase_c),
    .wrap_c      (wrap_c)
  );

  // Next state, repeat counter and next-cycle output values.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          en_d    = '{src: cmd_src, gourd: cmd_gourd, gourz: cmd_gourz};
          cnt_d   = (cmd_cnt == '0) ? (CW'(1) << CNT_W) : CW'(cmd_cnt);
          state_d = first_phase(en_d);
        end
      end
      ST_SRCLO, ST_SRCHI, ST_IINC, ST_ZINC: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (ld_q) begin
          if (wrap_c) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_d == '0) ? ST_DONE : nxt_phase_c;
          end else begin
            state_d = nxt_phase_c;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    sel_d   = sel_code(state_d);
    ld_d    = is_phase(state_d) && !dadd_stall;
    last_d  = is_phase(state_d) && is_last_phase(state_d, en_d) && (cnt_d == CW'(1));
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    ready_d = (state_d == ST_IDLE);
  end

  // State, counter, latched enables and registered outputs.
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      cnt_q   <= '0;
      sel_q   <= DADDB_IDLE;
      ld_q    <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      ld_q    <= ld_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign daddbsel_0 = sel_q[0];
  assign daddbsel_1 = sel_q[1];
  assign daddbsel_2 = sel_q[2];
  assign dadd_ld    = ld_q;
  assign dadd_last  = last_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
